// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word pipeline requests into one or two word
// accesses on a simple req/ack memory port, with alignment and range checks.
//
// state | meaning
// IDLE  | ready for a new request
// ACC0  | first (or only) word access in flight, waiting for mem_ack
// ACC1  | second word access of a word-crossing request
// RESP  | one-cycle response to the pipeline
module load_store_unit #(
  parameter int MEM_DEPTH        = 256,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  load_sel,
  input  logic [1:0]  store_sel,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  localparam logic [31:0] DEPTH_W = MEM_DEPTH;

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  lsel_q;
  logic        we_q;
  logic        split_q;
  logic [29:0] w1_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wdata_hi_q;
  logic [31:0] word0_q;

  logic [1:0]  a_off;
  logic [2:0]  a_size;
  logic [3:0]  a_end;
  logic        a_split;
  logic [29:0] a_w0;
  logic [29:0] a_w1;
  logic [7:0]  a_mask;
  logic [63:0] a_wdata;
  logic        a_err;
  logic [63:0] ld_words;
  logic [31:0] resp_data;

  function automatic logic [31:0] extend_load(input logic [2:0] sel,
                                              input logic [63:0] words,
                                              input logic [1:0] o);
    logic [63:0] sh;
    sh = words >> {o, 3'b000};
    case (sel)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'b0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return sh[31:0];
    endcase
  endfunction

  // Request decode, evaluated on the accept cycle only.
  always_comb begin
    a_size = 3'd4;
    if (req_we) begin
      case (store_sel)
        2'b00:   a_size = 3'd1;
        2'b01:   a_size = 3'd2;
        default: a_size = 3'd4;
      endcase
    end else begin
      case (load_sel[1:0])
        2'b00:   a_size = 3'd1;
        2'b01:   a_size = 3'd2;
        default: a_size = 3'd4;
      endcase
    end
  end

  assign a_off   = req_addr[1:0];
  assign a_end   = {2'b00, a_off} + {1'b0, a_size};
  assign a_split = (a_end > 4'd4);
  assign a_w0    = req_addr[31:2];
  assign a_w1    = a_w0 + 30'd1;
  assign a_mask  = ((8'd1 << a_size) - 8'd1) << a_off;
  assign a_wdata = {32'b0, req_wdata} << {a_off, 3'b000};

  always_comb begin
    a_err = 1'b0;
    if ({2'b00, a_w0} >= DEPTH_W)                  a_err = 1'b1;
    if (a_split && ({2'b00, a_w1} >= DEPTH_W))     a_err = 1'b1;
    if (a_split && (ALLOW_MISALIGNED == 0))        a_err = 1'b1;
    if (req_we && (store_sel == 2'b11))            a_err = 1'b1;
  end

  // Load data is formed straight from the acking word so RESP can present it registered.
  assign ld_words  = (state == ACC1) ? {mem_rdata, word0_q} : {32'b0, mem_rdata};
  assign resp_data = we_q ? 32'b0 : extend_load(lsel_q, ld_words, off_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      off_q      <= '0;
      lsel_q     <= '0;
      we_q       <= 1'b0;
      split_q    <= 1'b0;
      w1_q       <= '0;
      be_hi_q    <= '0;
      wdata_hi_q <= '0;
      word0_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            off_q      <= a_off;
            lsel_q     <= load_sel;
            we_q       <= req_we;
            split_q    <= a_split;
            w1_q       <= a_w1;
            be_hi_q    <= a_mask[7:4];
            wdata_hi_q <= a_wdata[63:32];
            if (a_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= ACC0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= a_w0;
              mem_be    <= a_mask[3:0];
              mem_wdata <= a_wdata[31:0];
            end
          end
        end
        ACC0: begin
          if (mem_ack) begin
            word0_q <= mem_rdata;
            if (split_q) begin
              state     <= ACC1;
              mem_addr  <= w1_q;
              mem_be    <= be_hi_q;
              mem_wdata <= wdata_hi_q;
            end else begin
              state      <= RESP;
              mem_req    <= 1'b0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= resp_data;
            end
          end
        end
        ACC1: begin
          if (mem_ack) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= resp_data;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: default instance plus a strict-alignment instance,
// backed by a small word memory that acks combinationally when enabled.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid_na = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  load_sel = '0;
  logic [1:0]  store_sel = '0;
  logic        ack_en = 1'b1;

  logic        req_ready, resp_valid, resp_err, mem_req, mem_we, mem_ack;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;

  logic        req_ready_na, resp_valid_na, resp_err_na, mem_req_na, mem_we_na;
  logic [31:0] resp_rdata_na, mem_wdata_na;
  logic [29:0] mem_addr_na;
  logic [3:0]  mem_be_na;
  logic        mem_ack_na = 1'b0;
  logic [31:0] mem_rdata_na = '0;

  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  logic [31:0] mem_model [256];
  logic [29:0] log_addr [32];
  logic [3:0]  log_be [32];
  logic [31:0] log_wd [32];
  int          n_log = 0;
  int          req_seen = 0;
  int          req_seen_na = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .load_sel(load_sel), .store_sel(store_sel),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.MEM_DEPTH(256), .ALLOW_MISALIGNED(0)) dut_na (
    .clk(clk), .rst(rst), .req_valid(req_valid_na), .req_ready(req_ready_na),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .load_sel(load_sel), .store_sel(store_sel),
    .resp_valid(resp_valid_na), .resp_rdata(resp_rdata_na), .resp_err(resp_err_na),
    .mem_req(mem_req_na), .mem_we(mem_we_na), .mem_addr(mem_addr_na), .mem_be(mem_be_na),
    .mem_wdata(mem_wdata_na), .mem_ack(mem_ack_na), .mem_rdata(mem_rdata_na)
  );

  assign mem_ack   = mem_req & ack_en;
  assign mem_rdata = mem_model[mem_addr[7:0]];

  always @(posedge clk) begin
    if (pl_en) mem_model[pl_addr] <= pl_data;
    if (mem_req) req_seen <= req_seen + 1;
    if (mem_req_na) req_seen_na <= req_seen_na + 1;
    if (mem_req && mem_ack) begin
      log_addr[n_log[4:0]] <= mem_addr;
      log_be[n_log[4:0]]   <= mem_be;
      log_wd[n_log[4:0]]   <= mem_wdata;
      n_log <= n_log + 1;
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem_model[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one request and waits for its response; lat counts cycles from accept.
  task automatic do_req(input bit na, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] ls, input logic [1:0] ss,
                        output int lat, output logic [31:0] rd, output logic er);
    bit found;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; load_sel = ls; store_sel = ss;
    if (na) req_valid_na = 1'b1; else req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_valid_na = 1'b0;
    found = 1'b0; lat = 1; rd = '0; er = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (na ? resp_valid_na : resp_valid) begin
        rd = na ? resp_rdata_na : resp_rdata;
        er = na ? resp_err_na : resp_err;
        found = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!found) lat = 99;
  endtask

  int          lat, base, seen0;
  logic [31:0] rd;
  logic        er;
  bit          any_resp;

  initial begin
    // reset state
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // aligned LW
    preload(8'd4, 32'h8899AABB);
    base = n_log;
    do_req(0, 0, 32'h10, 0, 3'b010, 2'b00, lat, rd, er);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", rd, 32'h8899AABB);
    check("lw_err", 32'(er), 32'd0);
    check("lw_addr", 32'(log_addr[base[4:0]]), 32'd4);
    check("lw_be", 32'(log_be[base[4:0]]), 32'hF);
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
    check("resp_hold", resp_rdata, 32'h8899AABB);
    check("ready_again", 32'(req_ready), 32'd1);

    // byte/half loads with extension
    preload(8'd4, 32'h80112233);
    do_req(0, 0, 32'h13, 0, 3'b000, 2'b00, lat, rd, er);
    check("lb_rdata", rd, 32'hFFFFFF80);
    do_req(0, 0, 32'h13, 0, 3'b100, 2'b00, lat, rd, er);
    check("lbu_rdata", rd, 32'h00000080);
    do_req(0, 0, 32'h12, 0, 3'b101, 2'b00, lat, rd, er);
    check("lhu_rdata", rd, 32'h00008011);
    do_req(0, 0, 32'h12, 0, 3'b001, 2'b00, lat, rd, er);
    check("lh_rdata", rd, 32'hFFFF8011);

    // misaligned LW crossing words 1/2
    preload(8'd1, 32'h44332211);
    preload(8'd2, 32'h88776655);
    preload(8'd3, 32'h00000000);
    base = n_log;
    do_req(0, 0, 32'h06, 0, 3'b010, 2'b00, lat, rd, er);
    check("mis_lw_rdata", rd, 32'h66554433);
    check("mis_lw_err", 32'(er), 32'd0);
    check("mis_lw_lat", 32'(lat), 32'd3);
    check("mis_lw_addr0", 32'(log_addr[base[4:0]]), 32'd1);
    check("mis_lw_be0", 32'(log_be[base[4:0]]), 32'hC);
    check("mis_lw_addr1", 32'(log_addr[5'(base + 1)]), 32'd2);
    check("mis_lw_be1", 32'(log_be[5'(base + 1)]), 32'h3);

    // same access on the strict-alignment instance
    do_req(1, 0, 32'h06, 0, 3'b010, 2'b00, lat, rd, er);
    check("na_err", 32'(er), 32'd1);
    check("na_rdata", rd, 32'd0);
    check("na_lat", 32'(lat), 32'd1);
    check("na_no_mem_req", 32'(req_seen_na), 32'd0);

    // split SH
    base = n_log;
    do_req(0, 1, 32'h0B, 32'h0000CAFE, 3'b000, 2'b01, lat, rd, er);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_rdata", rd, 32'd0);
    check("sh_err", 32'(er), 32'd0);
    check("sh_addr0", 32'(log_addr[base[4:0]]), 32'd2);
    check("sh_be0", 32'(log_be[base[4:0]]), 32'h8);
    check("sh_wd0", log_wd[base[4:0]], 32'hFE000000);
    check("sh_addr1", 32'(log_addr[5'(base + 1)]), 32'd3);
    check("sh_be1", 32'(log_be[5'(base + 1)]), 32'h1);
    check("sh_wd1", log_wd[5'(base + 1)], 32'h000000CA);
    check("sh_mem2", mem_model[2], 32'hFE776655);
    check("sh_mem3", mem_model[3], 32'h000000CA);
    do_req(0, 0, 32'h0B, 0, 3'b101, 2'b00, lat, rd, er);
    check("lhu_split", rd, 32'h0000CAFE);
    do_req(0, 0, 32'h0B, 0, 3'b001, 2'b00, lat, rd, er);
    check("lh_split", rd, 32'hFFFFCAFE);

    // range and encoding errors
    seen0 = req_seen;
    do_req(0, 0, 32'h400, 0, 3'b010, 2'b00, lat, rd, er);
    check("oob_lw_err", 32'(er), 32'd1);
    check("oob_lw_rdata", rd, 32'd0);
    check("oob_lw_lat", 32'(lat), 32'd1);
    do_req(0, 1, 32'h3FE, 32'h11223344, 3'b000, 2'b10, lat, rd, er);
    check("oob_sw_err", 32'(er), 32'd1);
    do_req(0, 1, 32'h20, 32'h11223344, 3'b000, 2'b11, lat, rd, er);
    check("bad_ssel_err", 32'(er), 32'd1);
    check("err_no_mem_req", 32'(req_seen - seen0), 32'd0);

    // aligned SW
    base = n_log;
    do_req(0, 1, 32'h20, 32'h12345678, 3'b000, 2'b10, lat, rd, er);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_err", 32'(er), 32'd0);
    check("sw_be", 32'(log_be[base[4:0]]), 32'hF);
    check("sw_mem8", mem_model[8], 32'h12345678);

    // reset while ACC0 waits on a withheld ack
    ack_en = 1'b0;
    base = n_log;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; load_sel = 3'b010; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("stall_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    #1 rst = 1'b0;
    ack_en = 1'b1;
    any_resp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) any_resp = 1'b1;
    end
    check("arst_no_resp", 32'(any_resp), 32'd0);
    check("arst_no_ack", 32'(n_log - base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning data memory size in 32-bit words.
REQ-002 SHALL have parameter ALLOW_MISALIGNED, default 1, meaning 1 = split word-crossing accesses, 0 = flag them as errors.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports req_valid input 1 and req_ready output 1, the pipeline request handshake.
REQ-006 SHALL have ports req_we input 1 (1 = store), req_addr input 32 (byte address), req_wdata input 32 (store data, LSB-aligned).
REQ-007 SHALL have ports load_sel input 3 (000 B, 001 H, 010 W, 100 BU, 101 HU) and store_sel input 2 (00 B, 01 H, 10 W).
REQ-008 SHALL have ports resp_valid output 1, resp_rdata output 32 (extended load data) and resp_err output 1.
REQ-009 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output 30 (word address), mem_be output 4, mem_wdata output 32.
REQ-010 SHALL have ports mem_ack input 1 and mem_rdata input 32 (word read data, valid with mem_ack).

Function
REQ-011 SHALL implement FSM states IDLE, ACC0, ACC1, RESP.
REQ-012 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle with req_valid&&req_ready, latching all request fields.
REQ-013 SHALL compute at accept: o=req_addr[1:0], size (1/2/4 bytes), split = o+size>4, w0=req_addr[31:2], w1=w0+1.
REQ-014 SHALL set err at accept if w0>=MEM_DEPTH, or split&&w1>=MEM_DEPTH, or split&&ALLOW_MISALIGNED==0, or store with store_sel=11.
REQ-015 SHALL go IDLE->RESP on err (no memory transaction issued); otherwise IDLE->ACC0.
REQ-016 SHALL in ACC0 hold mem_req=1 with mem_addr=w0 and stable mem_we/mem_be/mem_wdata until mem_ack=1.
REQ-017 SHALL on mem_ack in ACC0 go to ACC1 if split, else RESP; ACC1 identical with mem_addr=w1, exiting to RESP on mem_ack.
REQ-018 SHALL drive mem_req=0 in IDLE and RESP; a mem_ack while mem_req=0 is ignored.
REQ-019 SHALL generate byte enables as mask M = ((1<<size)-1)<<o (8 bits); ACC0 mem_be=M[3:0], ACC1 mem_be=M[7:4].
REQ-020 SHALL drive mem_wdata = ({32'b0,req_wdata}<<8*o)[31:0] in ACC0 and [63:32] in ACC1; don't-care for loads.
REQ-021 SHALL drive mem_be with the same masks for loads (informational) and mem_we=latched req_we.
REQ-022 SHALL capture mem_rdata on mem_ack into word0 (ACC0) / word1 (ACC1), word1=0 if not split.
REQ-023 SHALL form raw = ({word1,word0}>>8*o)[31:0], then resp_rdata = B: sext raw[7:0]; BU: zext raw[7:0]; H: sext raw[15:0]; HU: zext raw[15:0]; W or other codes: raw.
REQ-024 SHALL in RESP assert resp_valid=1 for exactly one cycle with resp_rdata and resp_err, then return to IDLE.
REQ-025 SHALL drive resp_rdata=0 for stores and for any err response.
REQ-026 SHALL hold resp_rdata and resp_err constant outside RESP at their last values (resp_valid=0).
REQ-027 SHALL give latency accept->resp_valid of 2 cycles for an unsplit access with mem_ack same cycle, 3 for split, 1 for err.

Reset
REQ-028 SHALL on rst=1 immediately force state IDLE, req_ready=1, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_err=0, resp_rdata=0.
REQ-029 SHALL abandon any in-flight access on reset mid-transaction; no response is produced for it.

Verification
REQ-030 SHALL verify aligned LW addr 0x10, mem word 4 = 0x8899AABB, ack in same cycle -> mem_addr=4, mem_be=1111, resp_rdata=0x8899AABB, resp_valid 2 cycles after accept.
REQ-031 SHALL verify LB addr 0x13 word=0x80112233 -> resp_rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x12 -> 0x00008011.
REQ-032 SHALL verify SH addr 0x0B data 0x0000CAFE -> ACC0 addr 2 be=1000 wdata[31:24]=0xFE, ACC1 addr 3 be=0001 wdata[7:0]=0xCA.
REQ-033 SHALL verify misaligned LW addr 0x06, word1=0x44332211, word2=0x88776655 -> resp_rdata=0x66554433, resp_err=0; with ALLOW_MISALIGNED=0 -> resp_err=1, no mem_req.
REQ-034 SHALL verify addr 0x400 (MEM_DEPTH=256) and SW to 0x3FE -> resp_err=1, resp_rdata=0, mem_req never asserted.
REQ-035 SHALL verify mem_ack held low 5 cycles in ACC0 with rst pulsed at cycle 3 -> mem_req=0 immediately, req_ready=1, no resp_valid.
